// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline. Drives the
//   write/flush/bubble controls of the IF/ID and ID/EX registers, holds the
//   whole pipe while data memory is busy, and latches a sticky error when a
//   memory wait lasts TIMEOUT cycles. Saturating counters record stalls,
//   flushes and holds for performance debug.
//
// Parameters
//   TIMEOUT : consecutive memory-wait cycles that trigger the error (>= 2)
//   CNT_W   : width of the event counters
//
// Ports
//   clk, rst                            clock, async active-low reset
//   IF_ID_RegisterRs/Rt, ID_UsesRt      sources of the instruction in ID
//   ID_Jump                             jump decoded in ID
//   ID_EX_MemRead, ID_EX_RegisterRt     load in EX and its destination
//   EX_Branch_taken                     branch in EX resolved taken
//   EX_MEM_MemAccess, dmem_ready        MEM-stage access and its completion
//   PC_Write, IF_ID_Write               PC / IF/ID write enables
//   IF_ID_Flush                         load IF/ID with a NOP
//   ID_Hazard_lwstall                   zero ID/EX control fields (bubble)
//   ID_Hazard_Branch                    flush ID/EX
//   pipe_hold                           ID/EX, EX/MEM, MEM/WB keep contents
//   mem_timeout                         sticky memory-wait timeout flag
//   stall_cnt, flush_cnt, hold_cnt      saturating event counters

module hazard_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             ID_UsesRt,
  input  logic             ID_Jump,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic             EX_Branch_taken,
  input  logic             EX_MEM_MemAccess,
  input  logic             dmem_ready,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_Hazard_lwstall,
  output logic             ID_Hazard_Branch,
  output logic             pipe_hold,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HOLD = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;

  logic mem_wait;
  logic load_use;
  logic running;

  assign mem_wait = EX_MEM_MemAccess & ~dmem_ready;
  assign load_use = ID_EX_MemRead & (ID_EX_RegisterRt != 5'd0) &
                    ((ID_EX_RegisterRt == IF_ID_RegisterRs) |
                     (ID_UsesRt & (ID_EX_RegisterRt == IF_ID_RegisterRt)));
  assign running  = (state != ERR);

  // Zero-latency control decode. The pipeline registers sample these at the
  // next edge, so they must follow the inputs within the same cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned
    // (which would infer a latch); the priority chain then overrides.
    PC_Write          = 1'b1;
    IF_ID_Write       = 1'b1;
    IF_ID_Flush       = 1'b0;
    ID_Hazard_lwstall = 1'b0;
    ID_Hazard_Branch  = 1'b0;
    pipe_hold         = 1'b0;

    if (!rst || state == ERR || mem_wait) begin
      // Freeze everything; a pending branch or load-use is handled once the
      // pipe moves again, since both instructions are still in place.
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (EX_Branch_taken) begin
      // PC keeps loading so it takes the branch target; a load-use seen in ID
      // is on the wrong path and is dropped with the flush.
      IF_ID_Flush      = 1'b1;
      ID_Hazard_Branch = 1'b1;
    end else if (load_use) begin
      // A jump in ID also stalls here; its flush is issued next cycle.
      PC_Write          = 1'b0;
      IF_ID_Write       = 1'b0;
      ID_Hazard_lwstall = 1'b1;
    end else if (ID_Jump) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // Memory-wait watchdog. wait_cnt counts consecutive mem_wait cycles seen so
  // far; the TIMEOUT-th one (wait_cnt == TIMEOUT-1 in HOLD) enters ERR.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments and every register
    // here is reset asynchronously so a reset in ERR clears the flag at once.
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= HOLD;
            wait_cnt <= WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        HOLD: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ERR;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR: begin
          // Held until reset.
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Saturating event counters; frozen in ERR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      hold_cnt  <= '0;
    end else if (running) begin
      if (ID_Hazard_lwstall && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_ID_Flush       && flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + CNT_W'(1);
      if (pipe_hold         && hold_cnt  != CNT_MAX) hold_cnt  <= hold_cnt  + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl (TIMEOUT=4, CNT_W=4).
// Expected control vectors are queued when stimulus is driven and popped when
// the combinational outputs are sampled mid-cycle. Control vector bit order:
// {PC_Write, IF_ID_Write, IF_ID_Flush, ID_Hazard_lwstall, ID_Hazard_Branch, pipe_hold}.

module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;

  localparam logic [5:0] C_IDLE  = 6'b110000;
  localparam logic [5:0] C_HOLD  = 6'b000001;
  localparam logic [5:0] C_STALL = 6'b000100;
  localparam logic [5:0] C_BR    = 6'b111010;
  localparam logic [5:0] C_JUMP  = 6'b111000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [4:0]       IF_ID_RegisterRs = '0;
  logic [4:0]       IF_ID_RegisterRt = '0;
  logic             ID_UsesRt = 1'b0;
  logic             ID_Jump = 1'b0;
  logic             ID_EX_MemRead = 1'b0;
  logic [4:0]       ID_EX_RegisterRt = '0;
  logic             EX_Branch_taken = 1'b0;
  logic             EX_MEM_MemAccess = 1'b0;
  logic             dmem_ready = 1'b0;
  logic             PC_Write, IF_ID_Write, IF_ID_Flush;
  logic             ID_Hazard_lwstall, ID_Hazard_Branch, pipe_hold, mem_timeout;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, hold_cnt;
  logic [5:0]       ctl;

  assign ctl = {PC_Write, IF_ID_Write, IF_ID_Flush, ID_Hazard_lwstall, ID_Hazard_Branch, pipe_hold};

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .IF_ID_RegisterRs  (IF_ID_RegisterRs),
    .IF_ID_RegisterRt  (IF_ID_RegisterRt),
    .ID_UsesRt         (ID_UsesRt),
    .ID_Jump           (ID_Jump),
    .ID_EX_MemRead     (ID_EX_MemRead),
    .ID_EX_RegisterRt  (ID_EX_RegisterRt),
    .EX_Branch_taken   (EX_Branch_taken),
    .EX_MEM_MemAccess  (EX_MEM_MemAccess),
    .dmem_ready        (dmem_ready),
    .PC_Write          (PC_Write),
    .IF_ID_Write       (IF_ID_Write),
    .IF_ID_Flush       (IF_ID_Flush),
    .ID_Hazard_lwstall (ID_Hazard_lwstall),
    .ID_Hazard_Branch  (ID_Hazard_Branch),
    .pipe_hold         (pipe_hold),
    .mem_timeout       (mem_timeout),
    .stall_cnt         (stall_cnt),
    .flush_cnt         (flush_cnt),
    .hold_cnt          (hold_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] ctl;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Drive one cycle of inputs and queue the control vector they must produce.
  task automatic drive(input logic mr, input logic [4:0] ex_rt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic uses, input logic jmp,
                       input logic br, input logic acc, input logic rdy,
                       input logic [5:0] exp_ctl, input string tag);
    exp_t e;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = ex_rt;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    ID_UsesRt        = uses;
    ID_Jump          = jmp;
    EX_Branch_taken  = br;
    EX_MEM_MemAccess = acc;
    dmem_ready       = rdy;
    e.ctl = exp_ctl;
    e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic set_idle();
    ID_EX_MemRead    = 1'b0;
    ID_EX_RegisterRt = '0;
    IF_ID_RegisterRs = '0;
    IF_ID_RegisterRt = '0;
    ID_UsesRt        = 1'b0;
    ID_Jump          = 1'b0;
    EX_Branch_taken  = 1'b0;
    EX_MEM_MemAccess = 1'b0;
    dmem_ready       = 1'b0;
  endtask

  // Reset spanning one rising edge; returns just after a falling edge.
  task automatic do_reset();
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    @(negedge clk);
    set_idle();
    rst = 1'b0;
    e.ctl = C_HOLD;
    e.tag = "reset_ctl";
    exp_q.push_back(e);
    #2;
    e = exp_q.pop_front();
    checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    checks++;
    if ({mem_timeout, stall_cnt, flush_cnt, hold_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_state got to=%b s=%0d f=%0d h=%0d exp all 0", mem_timeout, stall_cnt, flush_cnt, hold_cnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_load_use();
    exp_t e;
    do_reset();
    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, C_STALL, "lu_rs");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd1) begin errors++; $display("FAIL lu_cnt got %0d exp 1", stall_cnt); end
    drive(0, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, 0, C_IDLE, "lu_after");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    drive(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, C_IDLE, "lu_r0");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    drive(1, 5'd7, 5'd3, 5'd7, 1, 0, 0, 0, 0, C_STALL, "lu_rt_used");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    drive(1, 5'd7, 5'd3, 5'd7, 0, 0, 0, 0, 0, C_IDLE, "lu_rt_unused");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    checks++;
    if (stall_cnt !== 4'd2) begin errors++; $display("FAIL lu_cnt2 got %0d exp 2", stall_cnt); end
  endtask

  task automatic test_branch();
    exp_t e;
    do_reset();
    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 0, 0, C_BR, "br_over_lu");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    checks++;
    if ({flush_cnt, stall_cnt} !== {4'd1, 4'd0}) begin
      errors++; $display("FAIL br_cnt got f=%0d s=%0d exp f=1 s=0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_jump_stall();
    exp_t e;
    do_reset();
    drive(1, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, 0, C_STALL, "jmp_stalled");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    drive(0, 5'd9, 5'd9, 5'd0, 0, 1, 0, 0, 0, C_JUMP, "jmp_flush");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    checks++;
    if ({stall_cnt, flush_cnt} !== {4'd1, 4'd1}) begin
      errors++; $display("FAIL jmp_cnt got s=%0d f=%0d exp s=1 f=1", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_mem_hold();
    exp_t e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 1, 0, C_HOLD, "hold_wait");
      #2; e = exp_q.pop_front(); checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d] got %b exp %b", e.tag, i, ctl, e.ctl); end
      @(negedge clk);
    end
    drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 1, 1, 1, C_BR, "hold_release_br");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
    checks++;
    if ({hold_cnt, flush_cnt, stall_cnt, mem_timeout} !== {4'd3, 4'd1, 4'd0, 1'b0}) begin
      errors++;
      $display("FAIL hold_cnt got h=%0d f=%0d s=%0d to=%b exp h=3 f=1 s=0 to=0", hold_cnt, flush_cnt, stall_cnt, mem_timeout);
    end
    // Back in RUN: a fresh 3-cycle wait must not time out.
    for (int i = 0; i < 3; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, C_HOLD, "hold_again");
      #2; e = exp_q.pop_front(); checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d] got %b exp %b", e.tag, i, ctl, e.ctl); end
      @(negedge clk);
    end
    checks++;
    if ({mem_timeout, hold_cnt} !== {1'b0, 4'd6}) begin
      errors++; $display("FAIL hold_again_state got to=%b h=%0d exp to=0 h=6", mem_timeout, hold_cnt);
    end
  endtask

  task automatic test_timeout();
    exp_t e;
    // Ready on the TIMEOUT-th cycle avoids the error.
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, (i == TIMEOUT - 1), (i == TIMEOUT - 1) ? C_IDLE : C_HOLD, "to_avoid");
      #2; e = exp_q.pop_front(); checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d] got %b exp %b", e.tag, i, ctl, e.ctl); end
      @(negedge clk);
    end
    checks++;
    if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_avoid_flag got %b exp 0", mem_timeout); end

    // Sustained wait: flag rises on the TIMEOUT-th edge.
    do_reset();
    for (int i = 0; i < TIMEOUT; i++) begin
      drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, C_HOLD, "to_wait");
      #2; e = exp_q.pop_front(); checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d] got %b exp %b", e.tag, i, ctl, e.ctl); end
      @(negedge clk);
      checks++;
      if (mem_timeout !== (i == TIMEOUT - 1)) begin
        errors++; $display("FAIL to_flag[%0d] got %b exp %b", i, mem_timeout, (i == TIMEOUT - 1));
      end
    end
    // ERR: hold regardless of inputs, sticky flag, frozen counters.
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 0, 0, C_HOLD, "err_hold");
      #2; e = exp_q.pop_front(); checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d] got %b exp %b", e.tag, i, ctl, e.ctl); end
      @(negedge clk);
    end
    checks++;
    if ({mem_timeout, hold_cnt, flush_cnt, stall_cnt} !== {1'b1, 4'd4, 4'd0, 4'd0}) begin
      errors++;
      $display("FAIL err_sticky got to=%b h=%0d f=%0d s=%0d exp to=1 h=4 f=0 s=0", mem_timeout, hold_cnt, flush_cnt, stall_cnt);
    end
    // Asynchronous reset mid-cycle clears everything without a clock edge.
    set_idle();
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_timeout, hold_cnt, ctl} !== {1'b0, 4'd0, C_HOLD}) begin
      errors++; $display("FAIL err_async_rst got to=%b h=%0d ctl=%b exp to=0 h=0 ctl=%b", mem_timeout, hold_cnt, ctl, C_HOLD);
    end
    @(negedge clk);
    rst = 1'b1;
    drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, C_JUMP, "after_err_rst");
    #2; e = exp_q.pop_front(); checks++;
    if (ctl !== e.ctl) begin errors++; $display("FAIL %s got %b exp %b", e.tag, ctl, e.ctl); end
    @(negedge clk);
  endtask

  task automatic test_saturation();
    exp_t e;
    int   want;
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      drive(1, 5'd12, 5'd12, 5'd0, 0, 0, 0, 0, 0, C_STALL, "sat_stall");
      #2; e = exp_q.pop_front(); checks++;
      if (ctl !== e.ctl) begin errors++; $display("FAIL %s[%0d] got %b exp %b", e.tag, i, ctl, e.ctl); end
      @(negedge clk);
      want = (i < 15) ? i : 15;
      checks++;
      if (stall_cnt !== want[CNT_W-1:0]) begin
        errors++; $display("FAIL sat_cnt[%0d] got %0d exp %0d", i, stall_cnt, want);
      end
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_jump_stall();
    test_mem_hold();
    test_timeout();
    test_saturation();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It sits beside the IF/ID and ID/EX pipeline registers and drives their write, flush and bubble controls, including the `ID_Hazard_lwstall` and `ID_Hazard_Branch` inputs of ID_EX. It covers three cases: load-use stalls, taken-branch flushes resolved in EX, and whole-pipe holds while data memory is not ready. A watchdog FSM latches a fatal error on a memory-wait timeout, and saturating event counters support performance debug.

## Interface
- `TIMEOUT`, 256: number of consecutive memory-wait cycles before entering ERR (≥2).
- `CNT_W`, 16: event counter width.

- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset: one clock, asynchronous, active-low.
- `IF_ID_RegisterRs`, `IF_ID_RegisterRt`  in  5  source registers of the instruction in ID.
- `ID_UsesRt`  in  1  instruction in ID reads rt.
- `ID_Jump`  in  1  jump decoded in ID.
- `ID_EX_MemRead`  in  1  instruction in EX is a load.
- `ID_EX_RegisterRt`  in  5  load destination in EX.
- `EX_Branch_taken`  in  1  branch in EX resolved taken.
- `EX_MEM_MemAccess`  in  1  MEM stage issues a data-memory access.
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `PC_Write`, `IF_ID_Write`  out  1  enables for PC and IF/ID.
- `IF_ID_Flush`  out  1  IF/ID is loaded with a NOP.
- `ID_Hazard_lwstall`  out  1  ID/EX control fields are zeroed (bubble).
- `ID_Hazard_Branch`  out  1  ID/EX is flushed.
- `pipe_hold`  out  1  ID/EX, EX/MEM and MEM/WB hold their contents.
- `mem_timeout`  out  1  sticky error flag.
- `stall_cnt`, `flush_cnt`, `hold_cnt`  out  CNT_W  saturating event counters.

## Operation
- Definitions:
  - `mem_wait = EX_MEM_MemAccess & ~dmem_ready`.
  - `load_use = ID_EX_MemRead & (ID_EX_RegisterRt != 0) & ((ID_EX_RegisterRt == IF_ID_RegisterRs) | (ID_UsesRt & ID_EX_RegisterRt == IF_ID_RegisterRt))`.
- Output decode is combinational from the inputs and the state. The first matching priority row applies; any output not named in a row takes its default.
  - Defaults: `PC_Write=1`, `IF_ID_Write=1`, all other control outputs 0.
  - 1. `rst`=0, or state ERR: `PC_Write=0`, `IF_ID_Write=0`, `pipe_hold=1`.
  - 2. `mem_wait`: `PC_Write=0`, `IF_ID_Write=0`, `pipe_hold=1`. No flush or bubble is issued, even if `EX_Branch_taken` or `load_use` is also true.
  - 3. `EX_Branch_taken`: `IF_ID_Flush=1`, `ID_Hazard_Branch=1`. `PC_Write` stays 1 so the PC loads the target. A concurrent `load_use` is suppressed because it belongs to the wrong path.
  - 4. `load_use`: `PC_Write=0`, `IF_ID_Write=0`, `ID_Hazard_lwstall=1`. A concurrent `ID_Jump` waits; its flush occurs when the jump leaves the stall.
  - 5. `ID_Jump`: `IF_ID_Flush=1`.
- FSM states: RUN, HOLD, ERR. `wait_cnt` is an internal counter wide enough to reach TIMEOUT.
  - RUN: `mem_wait` → HOLD with `wait_cnt`=1. Otherwise stay in RUN with `wait_cnt`=0.
  - HOLD: `~mem_wait` → RUN with `wait_cnt`=0. `mem_wait` with `wait_cnt==TIMEOUT-1` → ERR. Otherwise `wait_cnt`+1.
  - ERR: held until reset. `mem_timeout`=1 is registered and asserted from the first ERR cycle.
- Counters, all saturating at 2^CNT_W−1 with no wrap:
  - `stall_cnt` +1 on each cycle with `ID_Hazard_lwstall`.
  - `flush_cnt` +1 on each cycle with `IF_ID_Flush`.
  - `hold_cnt` +1 on each cycle with `pipe_hold` while in RUN or HOLD.
- No counter updates in ERR or during reset.

## Timing
- Reset (`rst`=0, async): state=RUN, `wait_cnt`=0, `mem_timeout`=0, all counters 0. While reset is asserted, outputs follow priority row 1. The first edge after deassertion evaluates normally.
- Control outputs have zero latency: they are valid in the same cycle as the inputs and are sampled by the pipeline registers at the next rising edge.
- Load-use is exactly 1 bubble cycle. In the following cycle the load is in MEM, `load_use` is false, and the pipe proceeds.
- A taken branch is exactly one 1-cycle flush of both IF/ID and ID/EX.
- A hold lasts exactly as many cycles as `mem_wait` is true. The pipe advances on the edge ending the cycle in which `dmem_ready`=1.
- TIMEOUT consecutive `mem_wait` cycles cause ERR on the last of those edges. A `dmem_ready` pulse on the TIMEOUT-th cycle avoids ERR.
- A reset asserted mid-HOLD or in ERR returns the block to RUN immediately. `mem_timeout` clears asynchronously.

## Test plan
- Load-use:
  - Stimulus: `ID_EX_MemRead`=1, `ID_EX_RegisterRt`=5, `IF_ID_RegisterRs`=5 for 1 cycle.
  - Response: `ID_Hazard_lwstall`=1, `PC_Write`=0, `IF_ID_Write`=0 that cycle; `stall_cnt`=1 afterwards.
  - Repeat with Rt=0: no stall.
- Branch flush:
  - Stimulus: `EX_Branch_taken`=1 together with the load-use condition.
  - Response: `ID_Hazard_Branch`=1, `IF_ID_Flush`=1, `PC_Write`=1, `ID_Hazard_lwstall`=0; `flush_cnt`=1.
- Jump stalled:
  - Stimulus: `ID_Jump`=1 with load-use for 1 cycle, then `ID_Jump`=1 alone.
  - Response: cycle 1 stalls only; cycle 2 gives `IF_ID_Flush`=1.
- Memory hold:
  - Stimulus: `EX_MEM_MemAccess`=1, `dmem_ready`=0 for 3 cycles with `EX_Branch_taken`=1, then `dmem_ready`=1.
  - Response: `pipe_hold`=1 and no flush for 3 cycles; state RUN afterwards; `hold_cnt`=3.
  - Then flush asserts, because the branch is still in EX.
- Timeout:
  - Stimulus: TIMEOUT=4, `mem_wait` held.
  - Response: `mem_timeout`=1 after the 4th wait edge, sticky.
  - `dmem_ready`=1 on the 4th cycle instead: no error.
  - In ERR, async `rst`=0 mid-cycle clears `mem_timeout` and the counters immediately.
- Saturation:
  - Stimulus: CNT_W=4, 20 consecutive load-use cycles.
  - Response: `stall_cnt`=15 and holds at 15.
